// File: rtl/seg_scan_display.sv
// Eight-digit common-anode seven-segment scanner with an 8x6 digit memory,
// one registered slot per digit and a blanking gap at the start of each slot.
module seg_scan_display #(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       W,
   input  logic [2:0] WADD,
   input  logic [5:0] DIN,
   input  logic       lamp_test,
   output logic [7:0] AN,
   output logic [6:0] SEG,
   output logic       DP
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   logic [5:0]       r_mem [8];
   logic [CNT_W-1:0] r_div_cnt;
   logic [2:0]       r_idx;
   state_t           r_state;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_wrap;
   logic [5:0]       w_word;
   logic [7:0]       w_an;
   logic [6:0]       w_seg;
   logic             w_dp;

   function automatic logic [6:0] f_hex_decode(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

   // Writes are independent of the scan; a same-slot write shows one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) r_mem[i] <= 6'b000001;
      end else if (W) begin
         r_mem[WADD] <= DIN;
      end
   end

   assign w_wrap    = (r_div_cnt == CNT_LAST);
   assign w_cnt_nxt = w_wrap ? '0 : r_div_cnt + CNT_W'(1);
   assign w_word    = r_mem[r_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
         r_state   <= ST_BLANK;
      end else begin
         r_div_cnt <= w_cnt_nxt;
         if (w_wrap) r_idx <= r_idx + 3'd1;
         r_state   <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (BLANK_CYCLES == 0)
         w_state_nxt = ST_DRIVE;
      else if (w_wrap)
         w_state_nxt = ST_BLANK;
      else if (w_cnt_nxt == BLANK_END)
         w_state_nxt = ST_DRIVE;
   end

   // Disabled digits stay dark but still consume their slot.
   always_comb begin
      w_an  = 8'hFF;
      w_seg = 7'h7F;
      w_dp  = 1'b1;
      if (r_state == ST_DRIVE) begin
         if (lamp_test) begin
            w_an  = ~(8'd1 << r_idx);
            w_seg = 7'h00;
            w_dp  = 1'b0;
         end else if (w_word[5]) begin
            w_an  = ~(8'd1 << r_idx);
            w_seg = f_hex_decode(w_word[4:1]);
            w_dp  = w_word[0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN  <= 8'hFF;
         SEG <= 7'h7F;
         DP  <= 1'b1;
      end else begin
         AN  <= w_an;
         SEG <= w_seg;
         DP  <= w_dp;
      end
   end

endmodule
